fetch_stage: RTL and testbench

- Front-end stage directly upstream of dispatch. Generates the PC, requests instructions from instruction memory, and buffers the returned instructions in a small prefetch queue.
- Presents one instruction per cycle to dispatch.
- Honours the dispatch controls freeze, jump and halt, and the execute redirect branch_miss.
- Its fetch outputs are the fetch input of dispatch.

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, instruction-memory requests and a small prefetch
// queue that feeds dispatch one instruction per cycle.
// Ports:
//   CLK, nRST                 clock (rising edge), async active-low reset
//   imem_ren, imem_addr       instruction read request / word-aligned address
//   ihit, imem_load           memory response strobe / instruction data
//   freeze                    dispatch stall (head entry not consumed)
//   jump, jump_target         dispatch-resolved jump
//   branch_miss, branch_target execute redirect (wins over jump)
//   halt                      stop fetching permanently (wins over redirects)
//   fetch_valid/instr/pc      queue head presented to dispatch
//   halted                    fetch stopped until reset
module fetch_stage #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  output logic               imem_ren,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               ihit,
  input  logic [INSTR_W-1:0] imem_load,
  input  logic               freeze,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               branch_miss,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [PC_W-1:0]    fetch_pc,
  output logic               halted
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t              r_state, w_state_nx;
  logic                r_started;
  logic                r_halt_pend, w_halt_pend_nx;
  logic [PC_W-1:0]     r_pc, w_pc_nx;
  logic [PC_W-1:0]     r_drain_addr, w_drain_addr_nx;
  logic [PC_W-1:0]     r_q_pc    [QDEPTH];
  logic [INSTR_W-1:0]  r_q_instr [QDEPTH];
  logic [AW-1:0]       r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]       r_count;

  logic                w_req, w_hit, w_redirect;
  logic [PC_W-1:0]     w_target_raw, w_target;
  logic                w_push, w_pop, w_flush;

  // Request is held until ihit: in RUN the queue can only fill on ihit, and
  // DRAIN keeps presenting the captured address regardless of pc updates.
  // r_started keeps the request low while reset is asserted and for the
  // first cycle after release.
  assign w_req = r_started &&
                 (((r_state == S_RUN) && (r_count < CW'(QDEPTH))) || (r_state == S_DRAIN));
  assign w_hit        = w_req && ihit;
  assign w_redirect   = branch_miss || jump;
  assign w_target_raw = branch_miss ? branch_target : jump_target;
  assign w_target     = w_target_raw & ~PC_W'(3);

  assign imem_ren    = w_req;
  assign imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign fetch_valid = (r_count != '0);
  assign fetch_instr = r_q_instr[r_rd_ptr];
  assign fetch_pc    = r_q_pc[r_rd_ptr];
  assign halted      = (r_state == S_HALTED);

  // Next-state, pc and queue control.
  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_drain_addr_nx = r_drain_addr;
    w_halt_pend_nx  = r_halt_pend;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_flush         = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (halt) begin
          w_flush         = 1'b1;
          w_halt_pend_nx  = 1'b1;
          w_drain_addr_nx = r_pc;
          w_state_nx      = (w_req && !ihit) ? S_DRAIN : S_HALTED;
        end else if (w_redirect) begin
          // Data arriving with the redirect belongs to the wrong path.
          w_flush         = 1'b1;
          w_pc_nx         = w_target;
          w_drain_addr_nx = r_pc;
          if (w_req && !ihit) w_state_nx = S_DRAIN;
        end else begin
          w_push = w_hit;
          w_pop  = (r_count != '0) && !freeze;
          if (w_hit) w_pc_nx = r_pc + PC_W'(4);
        end
      end
      S_DRAIN: begin
        if (halt)            w_halt_pend_nx = 1'b1;
        else if (w_redirect) w_pc_nx        = w_target;
        if (w_hit) w_state_nx = (r_halt_pend || halt) ? S_HALTED : S_RUN;
      end
      S_HALTED: begin
      end
      default: w_state_nx = S_RUN;
    endcase
  end

  // Control state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= S_RUN;
      r_started    <= 1'b0;
      r_halt_pend  <= 1'b0;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
    end else begin
      r_state      <= w_state_nx;
      r_started    <= 1'b1;
      r_halt_pend  <= w_halt_pend_nx;
      r_pc         <= w_pc_nx;
      r_drain_addr <= w_drain_addr_nx;
    end
  end

  // Prefetch queue: flush overrides any push/pop in the same cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_wr_ptr]    <= r_pc;
        r_q_instr[r_wr_ptr] <= imem_load;
        r_wr_ptr            <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage. A simple
// instruction-memory responder (fixed latency, or held off) is driven from
// the stimulus sequence; memory contents are a fixed function of the address.
module tb_fetch_stage;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  logic               CLK = 1'b0;
  logic               nRST;
  logic               imem_ren;
  logic [PC_W-1:0]    imem_addr;
  logic               ihit;
  logic [INSTR_W-1:0] imem_load;
  logic               freeze;
  logic               jump;
  logic [PC_W-1:0]    jump_target;
  logic               branch_miss;
  logic [PC_W-1:0]    branch_target;
  logic               halt;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic [PC_W-1:0]    fetch_pc;
  logic               halted;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 0;
  int mem_cnt = 0;
  bit mem_hold = 1'b0;

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0), .QDEPTH(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .ihit(ihit), .imem_load(imem_load),
    .freeze(freeze), .jump(jump), .jump_target(jump_target),
    .branch_miss(branch_miss), .branch_target(branch_target),
    .halt(halt),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers a standing request after mem_lat waiting cycles.
  task automatic mem_drive();
    ihit      = 1'b0;
    imem_load = 32'hDEAD_BEEF;
    if (imem_ren) begin
      if (!mem_hold && mem_cnt >= mem_lat) begin
        ihit      = 1'b1;
        imem_load = mdata(imem_addr);
        mem_cnt   = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  task automatic step();
    mem_drive();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    freeze = 1'b0; jump = 1'b0; jump_target = '0;
    branch_miss = 1'b0; branch_target = '0; halt = 1'b0;
    ihit = 1'b0; imem_load = '0;
    mem_cnt = 0; mem_hold = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    nRST = 1'b0;
    clear_inputs();
    #2;
    chk("rst_ren",   imem_ren, 0);
    chk("rst_addr",  imem_addr, 0);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_instr", fetch_instr, 0);
    chk("rst_pc",    fetch_pc, 0);
    chk("rst_halted", halted, 0);

    // Sequential fetch, ihit one cycle after each request
    mem_lat = 1;
    do_reset();
    chk("s1_ren0", imem_ren, 1);
    chk("s1_addr0", imem_addr, 32'h0);
    step();
    chk("s1_hold_addr", imem_addr, 32'h0);
    chk("s1_hold_ren", imem_ren, 1);
    step();
    chk("s1_v0", fetch_valid, 1);
    chk("s1_pc0", fetch_pc, 32'h0);
    chk("s1_in0", fetch_instr, mdata(32'h0));
    chk("s1_addr4", imem_addr, 32'h4);
    step();
    chk("s1_pop_empty", fetch_valid, 0);
    step();
    chk("s1_pc4", fetch_pc, 32'h4);
    chk("s1_addr8", imem_addr, 32'h8);
    step();
    step();
    chk("s1_v8", fetch_valid, 1);
    chk("s1_pc8", fetch_pc, 32'h8);

    // Freeze with immediate ihit: queue fills to 2 and requests stop
    mem_lat = 0;
    do_reset();
    freeze = 1'b1;
    step();
    chk("s2_pc_a", fetch_pc, 32'h0);
    chk("s2_ren_a", imem_ren, 1);
    step();
    chk("s2_full_ren", imem_ren, 0);
    step(); step(); step();
    chk("s2_frz_ren", imem_ren, 0);
    chk("s2_frz_pc", fetch_pc, 32'h0);
    chk("s2_frz_addr", imem_addr, 32'h8);
    freeze = 1'b0;
    step();
    chk("s2_head4", fetch_pc, 32'h4);
    chk("s2_ren_back", imem_ren, 1);
    step();
    chk("s2_head8", fetch_pc, 32'h8);
    chk("s2_v8", fetch_valid, 1);

    // Jump while request to 0x8 is outstanding, ihit 3 cycles later
    do_reset();
    step();
    step();
    chk("s3_pc4", fetch_pc, 32'h4);
    mem_hold = 1'b1;
    step();
    chk("s3_out_addr", imem_addr, 32'h8);
    chk("s3_out_v", fetch_valid, 0);
    jump = 1'b1; jump_target = 32'h100;
    step();
    jump = 1'b0;
    chk("s3_drain_addr", imem_addr, 32'h8);
    chk("s3_drain_ren", imem_ren, 1);
    chk("s3_flush_v", fetch_valid, 0);
    step(); step();
    chk("s3_drain_addr2", imem_addr, 32'h8);
    mem_hold = 1'b0;
    step();
    chk("s3_discard_v", fetch_valid, 0);
    chk("s3_addr100", imem_addr, 32'h100);
    step();
    chk("s3_pc100", fetch_pc, 32'h100);
    chk("s3_in100", fetch_instr, mdata(32'h100));

    // jump and branch_miss together: branch_miss wins, coincident ihit discarded
    jump = 1'b1; jump_target = 32'h200;
    branch_miss = 1'b1; branch_target = 32'h300;
    step();
    jump = 1'b0; branch_miss = 1'b0;
    chk("s4_flush_v", fetch_valid, 0);
    chk("s4_addr300", imem_addr, 32'h300);
    step();
    chk("s4_pc300", fetch_pc, 32'h300);
    step();
    chk("s4_pc304", fetch_pc, 32'h304);

    // Unaligned target, then wrap of pc past the top of the address space
    jump = 1'b1; jump_target = 32'h403;
    step();
    chk("s4_align", imem_addr, 32'h400);
    jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    chk("s4_top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("s4_top_pc", fetch_pc, 32'hFFFF_FFFC);
    chk("s4_wrap_addr", imem_addr, 32'h0);

    // Halt with a request outstanding
    mem_hold = 1'b1;
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("s5_hold_ren", imem_ren, 1);
    chk("s5_hold_addr", imem_addr, 32'h0);
    chk("s5_flush_v", fetch_valid, 0);
    chk("s5_not_yet", halted, 0);
    step();
    chk("s5_hold_ren2", imem_ren, 1);
    mem_hold = 1'b0;
    step();
    chk("s5_ren_off", imem_ren, 0);
    chk("s5_halted", halted, 1);
    chk("s5_v", fetch_valid, 0);
    branch_miss = 1'b1; branch_target = 32'h40;
    step();
    branch_miss = 1'b0;
    step();
    chk("s5_bm_ren", imem_ren, 0);
    chk("s5_bm_halted", halted, 1);
    chk("s5_bm_v", fetch_valid, 0);

    // Reset pulsed during DRAIN
    do_reset();
    mem_hold = 1'b1;
    jump = 1'b1; jump_target = 32'h80;
    step();
    jump = 1'b0;
    chk("s6_drain_ren", imem_ren, 1);
    nRST = 1'b0;
    #1;
    chk("s6_async_ren", imem_ren, 0);
    chk("s6_async_addr", imem_addr, 32'h0);
    mem_hold = 1'b0;
    mem_cnt = 0;
    @(negedge CLK);
    nRST = 1'b1;
    step();
    chk("s6_ren", imem_ren, 1);
    chk("s6_addr", imem_addr, 32'h0);
    step();
    chk("s6_v", fetch_valid, 1);
    chk("s6_pc", fetch_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
